fifo_write_arb: RTL and testbench
=================================

# fifo_write_arb

Write-side arbiter for the 8-channel SyncFIFO. It collects write requests from eight client channels and picks one per cycle by rotating (round-robin) priority. The granted channel's data goes to the FIFO write port, and the chosen channel is acknowledged. An optional burst lock lets one channel keep the port for several back-to-back writes. The registered `select` output tells the read-side mux which channel wrote last.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one channel's write data
- BURST_MAX, 4, maximum consecutive writes per lock (≥1; 1 disables locking)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- wr_req  input  8  per-channel write request, bit i = channel i; held until acked
- wr_lock  input  8  per-channel burst-lock request, sampled with wr_req
- wr_data_in  input  8*DATA_WIDTH  channel i data at bits [i*DATA_WIDTH +: DATA_WIDTH]; held until acked
- full  input  1  FIFO full flag
- wr_en  output  1  FIFO write enable (combinational)
- wr_data  output  DATA_WIDTH  FIFO write data (combinational)
- wr_ack  output  8  one-hot; channel's word is consumed on this edge (combinational)
- select  output  8  one-hot, registered, last channel written
- locked  output  1  registered, high while in LOCKED state

## Operation
- State: two-state FSM `state` ∈ {IDLE, LOCKED}, plus:
  - rr_ptr (3 bit), the highest-priority channel.
  - owner (3 bit), the channel holding the lock.
  - cnt (width clog2(BURST_MAX+1)), writes done in the current lock.
- IDLE:
  - g = first i with wr_req[i]=1, searched rr_ptr, rr_ptr+1, … mod 8.
  - If any request and full=0:
    - wr_en=1, wr_ack[g]=1, wr_data = channel g data.
    - Next edge: rr_ptr = g+1 mod 8 (7 wraps to 0), select = one-hot(g).
    - If wr_lock[g]=1 and BURST_MAX>1: go to LOCKED, owner=g, cnt=1.
  - If no request, or full=1: wr_en=0, wr_ack=0, and all state holds.
- LOCKED:
  - Only the owner is eligible; other requests wait.
  - Owner writes when wr_req[owner]=1 and full=0: wr_en=1, wr_ack[owner]=1, cnt+1.
    - Return to IDLE when wr_lock[owner]=0 or cnt+1 = BURST_MAX. Otherwise stay.
  - wr_req[owner]=0: no write this cycle. Return to IDLE next edge (lock released).
  - full=1 with owner requesting: stall, no write, state/cnt unchanged.
  - rr_ptr stays owner+1 throughout the lock, so a released lock resumes fairly after the owner.
- When wr_en=0, wr_data follows the rr_ptr-selected (IDLE) or owner (LOCKED) channel data; it is don't-care.
- wr_en never asserts while full=1 (no overflow). wr_ack is always one-hot or zero, and wr_ack≠0 ⇔ wr_en=1.

## Timing
- Request to write latency: 0 cycles. wr_en, wr_ack and wr_data are combinational from wr_req/full and the registered state.
- The word transfers on the rising edge where wr_ack[i]=1. The client may change data/req after that edge.
- select, locked, rr_ptr, owner and cnt update on the edge that ends the write cycle.
- Reset values (async, immediate):
  - state=IDLE, rr_ptr=0, owner=0, cnt=0.
  - select=8'b0000_0001, locked=0.
  - wr_en=0 and wr_ack=0 while rst=1.
- A reset during LOCKED aborts the burst. The first grant after reset searches from channel 0.
- full toggling mid-burst only inserts stall cycles; lock length counts writes, not cycles.

## Structure
- Shared package fifo_pkg: CH_NUM=8, fifo_wr_state_t enum {IDLE, LOCKED}, SELECT_RST=8'b0000_0001.
- Sub-module fifo_rr_pick: combinational rotating-priority encoder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: valid, idx[2:0], onehot[7:0].

## Test plan
- Reset: assert rst mid-cycle with wr_req=8'hFF → wr_en=0, select=8'h01, locked=0 immediately.
- Single request: wr_req=8'h08, channel 3 data=8'hA5 → same cycle wr_en=1, wr_ack=8'h08, wr_data=8'hA5; next cycle select=8'h08.
- Fairness:
  - wr_req=8'hFF held, no locks, full=0 → acks 01,02,04,…,80 then 01 on consecutive cycles.
  - wr_req=8'h81 from reset → acks alternate 01, 80, 01.
- Full: full=1 with wr_req=8'h10 for 3 cycles → wr_en=0, rr_ptr/select unchanged; full=0 → channel 4 acked.
- Burst lock:
  - BURST_MAX=4, channel 5 with wr_lock=1, channel 6 also requesting → four channel-5 writes (locked=1 for 3 cycles after the first), then channel 6.
  - With full=1 for 2 cycles mid-burst → still exactly four channel-5 writes.
- Lock release: channel 2 locked, drops wr_req after 2 writes → no write that cycle, locked=0 next cycle, next grant from channel 3 onward.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the SyncFIFO write-side arbiter.
package fifo_pkg;

  localparam int CH_NUM   = 8;
  localparam int CH_IDX_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } fifo_wr_state_t;

  localparam logic [CH_NUM-1:0] SELECT_RST = 8'b0000_0001;

  // One-hot encode a channel index.
  function automatic logic [CH_NUM-1:0] idx2onehot(input logic [CH_IDX_W-1:0] idx);
    logic [CH_NUM-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating-priority encoder: first requesting channel at or after ptr (mod 8).
module fifo_rr_pick
  import fifo_pkg::*;
(
  input  logic [CH_NUM-1:0]   req,
  input  logic [CH_IDX_W-1:0] ptr,
  output logic                valid,
  output logic [CH_IDX_W-1:0] idx,
  output logic [CH_NUM-1:0]   onehot
);

  // Scan from farthest to nearest so the nearest requester wins; idx = ptr when idle.
  always_comb begin
    valid = |req;
    idx   = ptr;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (req[ptr + CH_IDX_W'(k)]) idx = ptr + CH_IDX_W'(k);
    end
    onehot = valid ? idx2onehot(idx) : '0;
  end

endmodule

// File: rtl/fifo_write_arb.sv
// Write-side arbiter: round-robin grant among 8 channels with optional burst lock.
module fifo_write_arb
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CH_NUM-1:0]            wr_req,
  input  logic [CH_NUM-1:0]            wr_lock,
  input  logic [CH_NUM*DATA_WIDTH-1:0] wr_data_in,
  input  logic                         full,
  output logic                         wr_en,
  output logic [DATA_WIDTH-1:0]        wr_data,
  output logic [CH_NUM-1:0]            wr_ack,
  output logic [CH_NUM-1:0]            select,
  output logic                         locked
);

  localparam int               CNT_W   = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam bit               LOCK_EN = (BURST_MAX > 1);

  fifo_wr_state_t        state_q;
  logic [CH_IDX_W-1:0]   rr_ptr_q;
  logic [CH_IDX_W-1:0]   owner_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [CH_NUM-1:0]     select_q;
  logic                  locked_q;

  logic                  pick_valid;
  logic [CH_IDX_W-1:0]   pick_idx;
  logic [CH_NUM-1:0]     pick_onehot;
  logic [CH_IDX_W-1:0]   cur_idx;
  logic                  grant;

  fifo_rr_pick u_pick (
    .req    (wr_req),
    .ptr    (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Grant decision: owner only while locked, rotating pick otherwise; never into a full FIFO.
  always_comb begin
    cur_idx = pick_idx;
    grant   = 1'b0;
    wr_ack  = '0;
    if (state_q == LOCKED) begin
      cur_idx = owner_q;
      grant   = wr_req[owner_q] && !full;
      if (grant) wr_ack = idx2onehot(owner_q);
    end else begin
      grant = pick_valid && !full;
      if (grant) wr_ack = pick_onehot;
    end
    if (rst) begin
      grant  = 1'b0;
      wr_ack = '0;
    end
    cnt_d = cnt_q + CNT_W'(1);
  end

  assign wr_en   = grant;
  assign wr_data = wr_data_in[cur_idx*DATA_WIDTH +: DATA_WIDTH];
  assign select  = select_q;
  assign locked  = locked_q;

  // Arbitration FSM: rotating pointer, last-writer select and burst-lock bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      select_q <= SELECT_RST;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            rr_ptr_q <= pick_idx + CH_IDX_W'(1);
            select_q <= pick_onehot;
            if (LOCK_EN && wr_lock[pick_idx]) begin
              state_q  <= LOCKED;
              owner_q  <= pick_idx;
              cnt_q    <= CNT_W'(1);
              locked_q <= 1'b1;
            end
          end
        end
        LOCKED: begin
          // Owner dropping its request releases the lock; full alone only stalls.
          if (!wr_req[owner_q]) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
          end else if (grant) begin
            select_q <= idx2onehot(owner_q);
            cnt_q    <= cnt_d;
            if (!wr_lock[owner_q] || (cnt_d == CNT_MAX)) begin
              state_q  <= IDLE;
              cnt_q    <= '0;
              locked_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arb.sv
// Directed self-checking bench for fifo_write_arb (DATA_WIDTH=8, BURST_MAX=4).
module tb_fifo_write_arb;

  logic        clk;
  logic        rst;
  logic [7:0]  wr_req;
  logic [7:0]  wr_lock;
  logic [63:0] wr_data_in;
  logic        full;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [7:0]  wr_ack;
  logic [7:0]  select;
  logic        locked;

  int n_cmp = 0;
  int n_err = 0;

  fifo_write_arb #(.DATA_WIDTH(8), .BURST_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_lock    (wr_lock),
    .wr_data_in (wr_data_in),
    .full       (full),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .select     (select),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         rst_b;
    logic [7:0] req;
    logic [7:0] lck;
    logic       full;
    logic       en;
    logic [7:0] ack;
    logic [7:0] data;
    logic [7:0] sel;
    logic       lk;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit rb, input logic [7:0] rq, input logic [7:0] lk_in,
                     input logic fl, input logic en, input logic [7:0] ack,
                     input logic [7:0] dat, input logic [7:0] sel, input logic lk);
    vec_t v;
    v.rst_b = rb; v.req = rq; v.lck = lk_in; v.full = fl; v.en = en;
    v.ack = ack; v.data = dat; v.sel = sel; v.lk = lk;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  int cnt5;
  int cnt6;
  bit saw6;

  initial begin
    rst = 1'b1; wr_req = '0; wr_lock = '0; full = 1'b0;
    for (int i = 0; i < 8; i++) wr_data_in[i*8 +: 8] = 8'hC0 + 8'(i);
    wr_data_in[3*8 +: 8] = 8'hA5;

    // rst_b, req, lock, full | en, ack, data, select(before edge), locked
    // single request on channel 3
    add(1, 8'h08, 8'h00, 0, 1, 8'h08, 8'hA5, 8'h01, 0);
    add(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h08, 0);
    // fairness with all channels requesting
    add(1, 8'hFF, 8'h00, 0, 1, 8'h01, 8'hC0, 8'h01, 0);
    add(0, 8'hFF, 8'h00, 0, 1, 8'h02, 8'hC1, 8'h01, 0);
    add(0, 8'hFF, 8'h00, 0, 1, 8'h04, 8'hC2, 8'h02, 0);
    add(0, 8'hFF, 8'h00, 0, 1, 8'h08, 8'hA5, 8'h04, 0);
    add(0, 8'hFF, 8'h00, 0, 1, 8'h10, 8'hC4, 8'h08, 0);
    add(0, 8'hFF, 8'h00, 0, 1, 8'h20, 8'hC5, 8'h10, 0);
    add(0, 8'hFF, 8'h00, 0, 1, 8'h40, 8'hC6, 8'h20, 0);
    add(0, 8'hFF, 8'h00, 0, 1, 8'h80, 8'hC7, 8'h40, 0);
    add(0, 8'hFF, 8'h00, 0, 1, 8'h01, 8'hC0, 8'h80, 0);
    // channels 0 and 7 alternate
    add(1, 8'h81, 8'h00, 0, 1, 8'h01, 8'hC0, 8'h01, 0);
    add(0, 8'h81, 8'h00, 0, 1, 8'h80, 8'hC7, 8'h01, 0);
    add(0, 8'h81, 8'h00, 0, 1, 8'h01, 8'hC0, 8'h80, 0);
    add(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h01, 0);
    // full holds pointer and select
    add(1, 8'h02, 8'h00, 0, 1, 8'h02, 8'hC1, 8'h01, 0);
    add(0, 8'h12, 8'h00, 1, 0, 8'h00, 8'h00, 8'h02, 0);
    add(0, 8'h12, 8'h00, 1, 0, 8'h00, 8'h00, 8'h02, 0);
    add(0, 8'h12, 8'h00, 1, 0, 8'h00, 8'h00, 8'h02, 0);
    add(0, 8'h12, 8'h00, 0, 1, 8'h10, 8'hC4, 8'h02, 0);
    add(0, 8'h02, 8'h00, 0, 1, 8'h02, 8'hC1, 8'h10, 0);
    // burst lock on channel 5 with channel 6 waiting
    add(1, 8'h60, 8'h20, 0, 1, 8'h20, 8'hC5, 8'h01, 0);
    add(0, 8'h60, 8'h20, 0, 1, 8'h20, 8'hC5, 8'h20, 1);
    add(0, 8'h60, 8'h20, 0, 1, 8'h20, 8'hC5, 8'h20, 1);
    add(0, 8'h60, 8'h20, 0, 1, 8'h20, 8'hC5, 8'h20, 1);
    add(0, 8'h40, 8'h00, 0, 1, 8'h40, 8'hC6, 8'h20, 0);
    add(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h40, 0);
    // lock release when owner drops its request
    add(1, 8'h0C, 8'h04, 0, 1, 8'h04, 8'hC2, 8'h01, 0);
    add(0, 8'h0C, 8'h04, 0, 1, 8'h04, 8'hC2, 8'h04, 1);
    add(0, 8'h09, 8'h04, 0, 0, 8'h00, 8'h00, 8'h04, 1);
    add(0, 8'h09, 8'h00, 0, 1, 8'h08, 8'hA5, 8'h04, 0);
    add(0, 8'h01, 8'h00, 0, 1, 8'h01, 8'hC0, 8'h08, 0);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      if (vq[i].rst_b) pulse_rst();
      wr_req  = vq[i].req;
      wr_lock = vq[i].lck;
      full    = vq[i].full;
      #1;
      chk($sformatf("v%0d.wr_en", i),  32'(wr_en),  32'(vq[i].en));
      chk($sformatf("v%0d.wr_ack", i), 32'(wr_ack), 32'(vq[i].ack));
      chk($sformatf("v%0d.select", i), 32'(select), 32'(vq[i].sel));
      chk($sformatf("v%0d.locked", i), 32'(locked), 32'(vq[i].lk));
      if (vq[i].en) chk($sformatf("v%0d.wr_data", i), 32'(wr_data), 32'(vq[i].data));
    end

    // Burst with two full cycles: still exactly four channel-5 writes, then channel 6.
    @(negedge clk);
    pulse_rst();
    wr_req = 8'h60; wr_lock = 8'h20; full = 1'b0;
    cnt5 = 0; cnt6 = 0; saw6 = 0;
    for (int c = 0; c < 20 && !saw6; c++) begin
      if (c > 0) @(negedge clk);
      full = (c == 2 || c == 3);
      #1;
      if (full) begin
        chk($sformatf("bf%0d.no_write_when_full", c), 32'(wr_en), 32'd0);
        chk($sformatf("bf%0d.locked_in_stall", c), 32'(locked), 32'd1);
      end
      if (wr_ack == 8'h20) cnt5++;
      if (wr_ack == 8'h40) begin
        cnt6++;
        saw6 = 1;
      end
    end
    chk("burst_full.ch5_writes", 32'(cnt5), 32'd4);
    chk("burst_full.ch6_granted", 32'(cnt6), 32'd1);

    // Asynchronous reset mid-burst aborts the lock and restarts the search at channel 0.
    @(negedge clk);
    pulse_rst();
    wr_req = 8'hFE; wr_lock = 8'hFE; full = 1'b0;
    #1;
    chk("rst_seq.first_ack", 32'(wr_ack), 32'h02);
    @(negedge clk);
    #1;
    chk("rst_seq.locked_before", 32'(locked), 32'd1);
    chk("rst_seq.select_before", 32'(select), 32'h02);
    #2;
    wr_req = 8'hFF;
    rst = 1'b1;
    #1;
    chk("rst_seq.wr_en", 32'(wr_en), 32'd0);
    chk("rst_seq.wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_seq.select", 32'(select), 32'h01);
    chk("rst_seq.locked", 32'(locked), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wr_lock = 8'h00;
    #1;
    chk("rst_seq.grant_from_0", 32'(wr_ack), 32'h01);

    @(negedge clk);
    wr_req = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
